// File: rtl/ioctl_upload_reader.sv
// HPS upload read responder: serves ioctl byte reads from a shared core RAM port.
// Stalls the HPS with ioctl_wait until the arbiter grants the port and data returns.
module ioctl_upload_reader #(
   parameter int          AW        = 12,
   parameter int          RD_LAT    = 2,
   parameter logic [7:0]  INDEX     = 8'd4,
   parameter logic [24:0] ADDR_BASE = 25'h0
) (
   input  logic          clk_sys,
   input  logic          reset_n,
   input  logic          ioctl_upload,
   input  logic [7:0]    ioctl_index,
   input  logic          ioctl_rd,
   input  logic [24:0]   ioctl_addr,
   output logic [7:0]    ioctl_din,
   output logic          ioctl_wait,
   output logic          ram_req,
   input  logic          ram_gnt,
   output logic [AW-1:0] ram_addr,
   output logic          ram_rd,
   input  logic [7:0]    ram_q,
   output logic          proto_err
);

   typedef enum logic [1:0] {IDLE, REQ, READ, LAT} state_t;

   localparam logic [2:0] LAT_END = 3'(RD_LAT);

   state_t      state;
   logic [2:0]  cnt;
   logic        active;
   logic [24:0] offs;
   logic        in_range;

   assign active   = ioctl_upload && (ioctl_index == INDEX);
   assign offs     = ioctl_addr - ADDR_BASE;
   assign in_range = (ioctl_addr >= ADDR_BASE) && ((offs >> AW) == 25'd0);

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         cnt        <= 3'd0;
         ioctl_din  <= 8'h00;
         ioctl_wait <= 1'b0;
         ram_req    <= 1'b0;
         ram_addr   <= '0;
         ram_rd     <= 1'b0;
         proto_err  <= 1'b0;
      end else begin
         ram_rd <= 1'b0;
         if (ioctl_rd && active && state != IDLE)
            proto_err <= 1'b1;
         case (state)
            IDLE: begin
               ioctl_wait <= 1'b0;
               if (ioctl_rd && active) begin
                  ioctl_wait <= 1'b1;
                  if (in_range) begin
                     ram_addr <= offs[AW-1:0];
                     ram_req  <= 1'b1;
                     state    <= REQ;
                  end else begin
                     ioctl_din <= 8'hFF;
                  end
               end
            end
            REQ: begin
               if (!active) begin
                  state      <= IDLE;
                  ram_req    <= 1'b0;
                  ioctl_wait <= 1'b0;
               end else if (ram_gnt) begin
                  ram_rd <= 1'b1;
                  state  <= READ;
               end
            end
            READ: begin
               if (!active) begin
                  state      <= IDLE;
                  ram_req    <= 1'b0;
                  ioctl_wait <= 1'b0;
               end else if (!ram_gnt) begin
                  state <= REQ;
               end else begin
                  cnt   <= 3'd1;
                  state <= LAT;
               end
            end
            LAT: begin
               if (!active) begin
                  state      <= IDLE;
                  cnt        <= 3'd0;
                  ram_req    <= 1'b0;
                  ioctl_wait <= 1'b0;
               end else if (!ram_gnt) begin
                  // grant lost mid-read: data is untrusted, re-read later
                  state <= REQ;
                  cnt   <= 3'd0;
               end else if (cnt == LAT_END) begin
                  ioctl_din  <= ram_q;
                  ioctl_wait <= 1'b0;
                  ram_req    <= 1'b0;
                  cnt        <= 3'd0;
                  state      <= IDLE;
               end else begin
                  cnt <= cnt + 3'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ioctl_upload_reader.sv
// Directed bench for ioctl_upload_reader with a latency RAM model
// and a scoreboard of expected returned bytes.
module tb_ioctl_upload_reader;

   localparam int          AW   = 12;
   localparam int          LAT  = 2;
   localparam logic [24:0] BASE = 25'h000100;

   logic          clk_sys = 1'b0;
   logic          reset_n;
   logic          ioctl_upload;
   logic [7:0]    ioctl_index;
   logic          ioctl_rd;
   logic [24:0]   ioctl_addr;
   logic [7:0]    ioctl_din;
   logic          ioctl_wait;
   logic          ram_req;
   logic          ram_gnt;
   logic [AW-1:0] ram_addr;
   logic          ram_rd;
   logic [7:0]    ram_q;
   logic          proto_err;

   int checks = 0;
   int errors = 0;

   logic [7:0] mem [4096];
   logic [7:0] pipe [LAT];
   logic       vld [LAT];
   int         rd_cnt = 0;
   int         nogrant = 0;
   logic [AW-1:0] rd_addr_seen;
   bit         req_seen;
   logic [7:0] sb [$];

   ioctl_upload_reader #(
      .AW(AW), .RD_LAT(LAT), .INDEX(8'd4), .ADDR_BASE(BASE)
   ) dut (
      .clk_sys(clk_sys), .reset_n(reset_n),
      .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
      .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
      .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
      .ram_req(ram_req), .ram_gnt(ram_gnt), .ram_addr(ram_addr),
      .ram_rd(ram_rd), .ram_q(ram_q), .proto_err(proto_err)
   );

   always #5 clk_sys = ~clk_sys;

   always @(posedge clk_sys) begin
      pipe[0] <= mem[ram_addr];
      vld[0]  <= ram_rd;
      for (int i = 1; i < LAT; i++) begin
         pipe[i] <= pipe[i-1];
         vld[i]  <= vld[i-1];
      end
      if (ram_rd) begin
         rd_cnt++;
         rd_addr_seen = ram_addr;
         if (!ram_gnt) nogrant++;
      end
      if (ram_req) req_seen = 1'b1;
   end

   assign ram_q = vld[LAT-1] ? pipe[LAT-1] : 8'hEE;

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_read(
      input  logic [24:0] addr,
      input  int gnt_low, input int drop_at, input int drop_len, input int extra_at,
      output int waits, output int rd_at, output int rds,
      output bit din_moved, output bit req_gap);
      logic [7:0] din0;
      int c, rd0;
      rd0 = rd_cnt; din0 = ioctl_din;
      rd_at = 0; din_moved = 0; req_gap = 0;
      ram_gnt = (gnt_low == 0);
      ioctl_addr = addr;
      ioctl_rd = 1'b1;
      tick();
      ioctl_rd = 1'b0;
      c = 1;
      while (ioctl_wait && c < 200) begin
         if (ram_rd) rd_at = c;
         if (ioctl_din !== din0) din_moved = 1;
         if (!ram_req) req_gap = 1;
         ram_gnt = !((c <= gnt_low) || (c >= drop_at && c < drop_at + drop_len));
         ioctl_rd = (c == extra_at);
         tick();
         c++;
      end
      ioctl_rd = 1'b0;
      ram_gnt = 1'b1;
      waits = c - 1;
      rds = rd_cnt - rd0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int w, ra, n;
      bit dm, rg;
      logic [7:0] d0;
      for (int i = 0; i < 4096; i++) mem[i] = 8'(i * 7 + 3);
      mem[5] = 8'hA7;
      reset_n = 1'b0; ioctl_upload = 1'b0; ioctl_index = 8'd0;
      ioctl_rd = 1'b0; ioctl_addr = '0; ram_gnt = 1'b1;
      #23;
      chk("rst_din", ioctl_din, 8'h00);
      chk("rst_wait", ioctl_wait, 1'b0);
      chk("rst_req", ram_req, 1'b0);
      chk("rst_rd", ram_rd, 1'b0);
      chk("rst_addr", ram_addr, 12'h000);
      chk("rst_err", proto_err, 1'b0);
      @(negedge clk_sys);
      reset_n = 1'b1;
      ioctl_upload = 1'b1; ioctl_index = 8'd4;
      tick();

      // basic read, grant tied high
      sb.push_back(mem[5]);
      run_read(BASE + 25'd5, 0, 0, 0, 0, w, ra, n, dm, rg);
      chk("t1_wait", w, 4);
      chk("t1_rdcyc", ra, 2);
      chk("t1_rdaddr", rd_addr_seen, 12'h005);
      chk("t1_rds", n, 1);
      chk("t1_din", ioctl_din, sb.pop_front());

      // grant held low for 10 cycles
      sb.push_back(mem[12'h123]);
      run_read(BASE + 25'h123, 10, 0, 0, 0, w, ra, n, dm, rg);
      chk("t2_wait", w, 14);
      chk("t2_rdcyc", ra, 12);
      chk("t2_rds", n, 1);
      chk("t2_din", ioctl_din, sb.pop_front());

      // just past the window and just below the base
      req_seen = 0;
      sb.push_back(8'hFF);
      run_read(BASE + 25'd4096, 0, 0, 0, 0, w, ra, n, dm, rg);
      chk("t3_wait", w, 1);
      chk("t3_rds", n, 0);
      chk("t3_req", req_seen, 1'b0);
      chk("t3_din", ioctl_din, sb.pop_front());
      tick();
      ioctl_din_reload: begin
         sb.push_back(mem[1]);
         run_read(BASE + 25'd1, 0, 0, 0, 0, w, ra, n, dm, rg);
         chk("t3b_din", ioctl_din, sb.pop_front());
      end
      req_seen = 0;
      sb.push_back(8'hFF);
      run_read(BASE - 25'd1, 0, 0, 0, 0, w, ra, n, dm, rg);
      chk("t3c_wait", w, 1);
      chk("t3c_req", req_seen, 1'b0);
      chk("t3c_din", ioctl_din, sb.pop_front());
      tick();

      // grant drops during latency: re-read same address
      sb.push_back(mem[9]);
      run_read(BASE + 25'd9, 0, 3, 3, 0, w, ra, n, dm, rg);
      chk("t4_wait", w, 9);
      chk("t4_rds", n, 2);
      chk("t4_rdcyc", ra, 7);
      chk("t4_rdaddr", rd_addr_seen, 12'h009);
      chk("t4_dinheld", dm, 1'b0);
      chk("t4_reqheld", rg, 1'b0);
      chk("t4_din", ioctl_din, sb.pop_front());

      // extra rd pulse during latency, top byte of the window
      chk("t5_err0", proto_err, 1'b0);
      sb.push_back(mem[12'hFFF]);
      run_read(BASE + 25'hFFF, 0, 0, 0, 3, w, ra, n, dm, rg);
      chk("t5_wait", w, 4);
      chk("t5_rds", n, 1);
      chk("t5_err", proto_err, 1'b1);
      chk("t5_din", ioctl_din, sb.pop_front());

      // wrong index: ignored
      d0 = ioctl_din;
      n = rd_cnt;
      ioctl_index = 8'd3;
      ioctl_addr = BASE + 25'd2;
      ioctl_rd = 1'b1;
      tick();
      ioctl_rd = 1'b0;
      chk("t5_idx_wait", ioctl_wait, 1'b0);
      chk("t5_idx_req", ram_req, 1'b0);
      tick(); tick(); tick();
      chk("t5_idx_rds", rd_cnt - n, 0);
      chk("t5_idx_din", ioctl_din, d0);
      ioctl_index = 8'd4;

      // upload drops while waiting for grant
      ram_gnt = 1'b0;
      ioctl_addr = BASE + 25'd3;
      ioctl_rd = 1'b1;
      tick();
      ioctl_rd = 1'b0;
      chk("t6_req_on", ram_req, 1'b1);
      chk("t6_wait_on", ioctl_wait, 1'b1);
      ioctl_upload = 1'b0;
      tick();
      chk("t6_abort_req", ram_req, 1'b0);
      chk("t6_abort_wait", ioctl_wait, 1'b0);
      chk("t6_abort_din", ioctl_din, d0);
      ioctl_upload = 1'b1;
      ram_gnt = 1'b1;
      tick();

      // async reset in the middle of latency
      ioctl_rd = 1'b1;
      tick();
      ioctl_rd = 1'b0;
      tick(); tick();
      #2 reset_n = 1'b0;
      #1;
      chk("t6_rst_din", ioctl_din, 8'h00);
      chk("t6_rst_wait", ioctl_wait, 1'b0);
      chk("t6_rst_req", ram_req, 1'b0);
      chk("t6_rst_addr", ram_addr, 12'h000);
      chk("t6_rst_err", proto_err, 1'b0);
      tick(); tick();
      @(negedge clk_sys);
      reset_n = 1'b1;
      tick(); tick(); tick();

      sb.push_back(mem[7]);
      run_read(BASE + 25'd7, 0, 0, 0, 0, w, ra, n, dm, rg);
      chk("t6_post_wait", w, 4);
      chk("t6_post_din", ioctl_din, sb.pop_front());
      chk("nogrant_rd", nogrant, 0);
      chk("sb_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
